// File: rtl/ram_fill_writer.sv
// Command-driven write/fill engine for the 32x4 dual-port RAM.
// Every fill is followed by a full read-back verify pass.
module ram_fill_writer #(
    parameter int RD_LAT = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_op,
    input  logic       cmd_inc,
    input  logic [4:0] cmd_addr,
    input  logic [3:0] cmd_data,
    output logic       wr_en,
    output logic [4:0] wr_addr,
    output logic [3:0] wr_data,
    output logic       rd_own,
    output logic [4:0] rd_addr,
    input  logic [3:0] rd_q,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [4:0] err_addr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_FILL,
        S_VERIFY,
        S_DONE
    } state_t;

    localparam logic [5:0] VLAST = 6'(31 + RD_LAT);
    localparam int         PL    = RD_LAT - 1;

    state_t     state;
    state_t     nxt;
    logic       inc_r;
    logic [3:0] data_r;
    logic [5:0] vcnt;
    logic       hs;
    logic       fill_last;
    logic       vlast;
    logic [4:0] fill_nxt;
    logic [3:0] fill_dat;
    logic [3:0] exp_dat;

    // Verify pipeline: address and expected value travel with each read
    logic [RD_LAT-1:0] pv;
    logic [4:0]        pa [RD_LAT];
    logic [3:0]        pe [RD_LAT];

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign hs        = cmd_valid && (state == S_IDLE);
    assign fill_last = (wr_addr == 5'd31);
    assign vlast     = (vcnt == VLAST);
    assign fill_nxt  = wr_addr + 5'd1;
    assign fill_dat  = data_r + (inc_r ? fill_nxt[3:0] : 4'd0);
    assign exp_dat   = data_r + (inc_r ? rd_addr[3:0] : 4'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE: begin
                if (hs) begin
                    nxt = cmd_op ? S_FILL : S_WRITE;
                end
            end
            S_WRITE: nxt = S_DONE;
            S_FILL: begin
                if (fill_last) begin
                    nxt = S_VERIFY;
                end
            end
            S_VERIFY: begin
                if (vlast) begin
                    nxt = S_DONE;
                end
            end
            S_DONE:  nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up with it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_en    <= 1'b0;
            rd_own   <= 1'b0;
            done     <= 1'b0;
            wr_addr  <= 5'd0;
            wr_data  <= 4'd0;
            rd_addr  <= 5'd0;
            inc_r    <= 1'b0;
            data_r   <= 4'd0;
            vcnt     <= 6'd0;
            err      <= 1'b0;
            err_addr <= 5'd0;
        end else begin
            wr_en  <= (nxt == S_WRITE) || (nxt == S_FILL);
            rd_own <= (nxt == S_VERIFY);
            done   <= (nxt == S_DONE);
            if (hs) begin
                inc_r    <= cmd_inc;
                data_r   <= cmd_data;
                err      <= 1'b0;
                err_addr <= 5'd0;
                wr_addr  <= cmd_op ? 5'd0 : cmd_addr;
                wr_data  <= cmd_data;
            end
            if (state == S_FILL) begin
                if (fill_last) begin
                    rd_addr <= 5'd0;
                    vcnt    <= 6'd0;
                end else begin
                    wr_addr <= fill_nxt;
                    wr_data <= fill_dat;
                end
            end
            if (state == S_VERIFY) begin
                vcnt <= vcnt + 6'd1;
                if (vcnt < 6'd31) begin
                    rd_addr <= rd_addr + 5'd1;
                end
            end
            if (pv[PL] && (rd_q != pe[PL]) && !err) begin
                err      <= 1'b1;
                err_addr <= pa[PL];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pv <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pa[i] <= 5'd0;
                pe[i] <= 4'd0;
            end
        end else begin
            pv[0] <= (state == S_VERIFY) && (vcnt < 6'd32);
            pa[0] <= rd_addr;
            pe[0] <= exp_dat;
            for (int i = 1; i < RD_LAT; i++) begin
                pv[i] <= pv[i-1];
                pa[i] <= pa[i-1];
                pe[i] <= pe[i-1];
            end
        end
    end

endmodule

// File: tb/tb_ram_fill_writer.sv
// Directed bench for ram_fill_writer with RAM models at RD_LAT 2, 1, 4.
// Instance 0 is the main target; 1 and 2 cover the latency sweep.
module tb_ram_fill_writer;

    logic clk;
    logic reset_n;
    logic op_i;
    logic inc_i;
    logic [4:0] addr_i;
    logic [3:0] data_i;
    logic [4:0] scan_addr;
    logic corrupt;

    logic [2:0] cv;
    logic [2:0] rdy;
    logic [2:0] wen;
    logic [2:0] rown;
    logic [2:0] bsy;
    logic [2:0] dn;
    logic [2:0] er;
    logic [2:0][4:0] waddr;
    logic [2:0][4:0] raddr;
    logic [2:0][4:0] eaddr;
    logic [2:0][3:0] wdata;
    logic [2:0][3:0] rq;

    int n_chk;
    int n_fail;
    int acc0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cv[0] && rdy[0]) acc0 <= acc0 + 1;
    end

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int L = (g == 1) ? 1 : ((g == 2) ? 4 : 2);
        logic [3:0] mem [32];
        logic [3:0] qp [4];
        logic [4:0] ap [4];
        logic [4:0] ra;

        assign ra = rown[g] ? raddr[g] : scan_addr;

        always @(posedge clk) begin
            if (wen[g]) mem[waddr[g]] <= wdata[g];
            qp[0] <= mem[ra];
            ap[0] <= ra;
            for (int i = 1; i < 4; i++) begin
                qp[i] <= qp[i-1];
                ap[i] <= ap[i-1];
            end
        end

        assign rq[g] = (corrupt && (ap[L-1] == 5'd9 || ap[L-1] == 5'd20))
                       ? 4'h0 : qp[L-1];

        ram_fill_writer #(.RD_LAT(L)) u_dut (
            .clk       (clk),
            .reset_n   (reset_n),
            .cmd_valid (cv[g]),
            .cmd_ready (rdy[g]),
            .cmd_op    (op_i),
            .cmd_inc   (inc_i),
            .cmd_addr  (addr_i),
            .cmd_data  (data_i),
            .wr_en     (wen[g]),
            .wr_addr   (waddr[g]),
            .wr_data   (wdata[g]),
            .rd_own    (rown[g]),
            .rd_addr   (raddr[g]),
            .rd_q      (rq[g]),
            .busy      (bsy[g]),
            .done      (dn[g]),
            .err       (er[g]),
            .err_addr  (eaddr[g])
        );
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     tag, got, got, exp, exp);
        end
    endtask

    // Issue one command, then watch the write stream and done timing
    task automatic run_cmd(input int g, input logic op, input logic inc,
                           input logic [4:0] a, input logic [3:0] d,
                           output int dcyc, output int wbad,
                           output int ndone);
        logic [3:0] e;
        @(negedge clk);
        op_i = op;
        inc_i = inc;
        addr_i = a;
        data_i = d;
        cv[g] = 1'b1;
        @(posedge clk);
        #1 cv[g] = 1'b0;
        dcyc = -1;
        wbad = 0;
        ndone = 0;
        for (int n = 1; n <= 120; n++) begin
            @(negedge clk);
            if (op && n <= 32) begin
                e = d + (inc ? 4'(n - 1) : 4'd0);
                if (!wen[g] || wdata[g] != e || waddr[g] != 5'(n - 1))
                    wbad++;
            end
            if (op && n > 32 && wen[g]) wbad++;
            if (!op && n == 1 &&
                (!wen[g] || waddr[g] != a || wdata[g] != d))
                wbad++;
            if (!op && n > 1 && wen[g]) wbad++;
            if (dn[g]) begin
                ndone++;
                if (dcyc < 0) dcyc = n;
            end
            if (dcyc > 0 && n >= dcyc + 2) break;
        end
    endtask

    task automatic scan(input int g, input logic [4:0] a,
                        output logic [3:0] q);
        @(negedge clk);
        scan_addr = a;
        repeat (6) @(negedge clk);
        q = rq[g];
    endtask

    int dc;
    int wb;
    int nd;
    int rf;
    int dfirst;
    logic [3:0] q;

    initial begin
        n_chk = 0;
        n_fail = 0;
        acc0 = 0;
        cv = '0;
        op_i = 1'b0;
        inc_i = 1'b0;
        addr_i = 5'd0;
        data_i = 4'd0;
        scan_addr = 5'd0;
        corrupt = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", rdy[0], 1);
        chk("rst_busy", bsy[0], 0);
        chk("rst_wren", wen[0], 0);
        chk("rst_rdown", rown[0], 0);
        chk("rst_done", dn[0], 0);
        chk("rst_err", er[0], 0);
        chk("rst_waddr", waddr[0], 0);
        chk("rst_wdata", wdata[0], 0);
        chk("rst_raddr", raddr[0], 0);
        chk("rst_eaddr", eaddr[0], 0);
        reset_n = 1'b1;
        @(negedge clk);

        run_cmd(0, 1'b0, 1'b0, 5'h13, 4'hA, dc, wb, nd);
        chk("wr_stream", wb, 0);
        chk("wr_done_cyc", dc, 2);
        chk("wr_done_cnt", nd, 1);
        chk("wr_ready", rdy[0], 1);
        scan(0, 5'h13, q);
        chk("wr_readback", q, 4'hA);

        run_cmd(0, 1'b1, 1'b1, 5'h00, 4'h3, dc, wb, nd);
        chk("inc_stream", wb, 0);
        chk("inc_done_cyc", dc, 67);
        chk("inc_err", er[0], 0);
        scan(0, 5'd31, q);
        chk("inc_rb31", q, 4'h2);
        scan(0, 5'd12, q);
        chk("inc_rb12", q, 4'hF);
        scan(0, 5'd13, q);
        chk("inc_rb13", q, 4'h0);

        corrupt = 1'b1;
        run_cmd(0, 1'b1, 1'b0, 5'h00, 4'h7, dc, wb, nd);
        corrupt = 1'b0;
        chk("bad_stream", wb, 0);
        chk("bad_done_cyc", dc, 67);
        chk("bad_err", er[0], 1);
        chk("bad_eaddr", eaddr[0], 9);
        run_cmd(0, 1'b0, 1'b0, 5'h02, 4'h5, dc, wb, nd);
        chk("clr_err", er[0], 0);
        chk("clr_eaddr", eaddr[0], 0);
        chk("clr_done_cyc", dc, 2);

        // Back-pressure: cmd_valid held high across a whole fill
        acc0 = 0;
        rf = -1;
        dfirst = -1;
        nd = 0;
        @(negedge clk);
        op_i = 1'b1;
        inc_i = 1'b0;
        data_i = 4'h5;
        cv[0] = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 150; n++) begin
            @(negedge clk);
            if (rdy[0] && rf < 0) rf = n;
            if (dn[0]) begin
                nd++;
                if (dfirst < 0) dfirst = n;
            end
            if (rf > 0 && n == rf + 1) cv[0] = 1'b0;
        end
        cv[0] = 1'b0;
        chk("bp_done_cyc", dfirst, 67);
        chk("bp_ready_cyc", rf, 68);
        chk("bp_accepts", acc0, 2);
        chk("bp_done_cnt", nd, 2);
        chk("bp_err", er[0], 0);

        // Asynchronous reset in cycle 20 of a fill
        @(negedge clk);
        op_i = 1'b1;
        inc_i = 1'b1;
        data_i = 4'h1;
        cv[0] = 1'b1;
        @(posedge clk);
        #1 cv[0] = 1'b0;
        repeat (20) @(negedge clk);
        chk("ar_pre_wren", wen[0], 1);
        reset_n = 1'b0;
        #1;
        chk("ar_wren", wen[0], 0);
        chk("ar_busy", bsy[0], 0);
        chk("ar_waddr", waddr[0], 0);
        @(negedge clk);
        reset_n = 1'b1;
        nd = 0;
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            if (dn[0]) nd++;
        end
        chk("ar_no_done", nd, 0);
        chk("ar_ready", rdy[0], 1);
        run_cmd(0, 1'b1, 1'b1, 5'h00, 4'h1, dc, wb, nd);
        chk("ar_fill_stream", wb, 0);
        chk("ar_fill_done", dc, 67);
        chk("ar_fill_err", er[0], 0);

        run_cmd(1, 1'b1, 1'b1, 5'h00, 4'h9, dc, wb, nd);
        chk("lat1_stream", wb, 0);
        chk("lat1_done_cyc", dc, 66);
        chk("lat1_err", er[1], 0);
        run_cmd(2, 1'b1, 1'b1, 5'h00, 4'hC, dc, wb, nd);
        chk("lat4_stream", wb, 0);
        chk("lat4_done_cyc", dc, 69);
        chk("lat4_err", er[2], 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_fill_writer.md
# ram_fill_writer

Command-driven write engine for the 32x4 dual-port RAM. It is the write-side counterpart of the one-second read scanner. It accepts single-word write commands or whole-array fill commands over a valid/ready handshake and drives the RAM write port. After every fill it reads back all 32 words through the RAM read port and compares each against the expected value, so the display path can show a self-checked pattern.

## Interface
- RD_LAT, default 2: RAM read latency in cycles, from rd_addr presented to rd_q valid. Legal range 1..4.
- clk  input  1  single clock, rising edge; same clock as the RAM.
- reset_n  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  engine can accept a command.
- cmd_op  input  1  0 = single write, 1 = fill all 32 addresses.
- cmd_inc  input  1  fill only: 1 = incrementing pattern, 0 = constant pattern.
- cmd_addr  input  5  single-write address; ignored for fill.
- cmd_data  input  4  write data (single write) or base value (fill).
- wr_en  output  1  RAM wren.
- wr_addr  output  5  RAM wraddress.
- wr_data  output  4  RAM data.
- rd_own  output  1  high while the engine owns the RAM read port; the top level muxes rd_addr over the scanner address.
- rd_addr  output  5  RAM rdaddress during verify.
- rd_q  input  4  RAM q.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when a command completes.
- err  output  1  sticky flag: the verify pass found a mismatch.
- err_addr  output  5  address of the first mismatch.

## Operation
- States: IDLE, WRITE, FILL, VERIFY, DONE.
- cmd_ready = (state == IDLE). A handshake is cmd_valid & cmd_ready at a rising edge. On a handshake the engine:
  - registers all cmd_* fields,
  - clears err and err_addr,
  - moves to WRITE if cmd_op = 0, or to FILL if cmd_op = 1.
- WRITE, 1 cycle: wr_en = 1, wr_addr = cmd_addr, wr_data = cmd_data. Next state is DONE.
- FILL, 32 cycles: wr_en = 1 and wr_addr counts 0..31.
  - wr_data = (cmd_data + (cmd_inc ? wr_addr[3:0] : 0)) mod 16, i.e. a 4-bit add that truncates.
  - After address 31 the next state is VERIFY.
- VERIFY, 32 + RD_LAT cycles:
  - rd_own = 1.
  - rd_addr counts 0..31 during the first 32 cycles, then holds 31.
  - A pipeline of depth RD_LAT carries each issued address and its expected value.
  - When an entry emerges, rd_q is compared with its expected value.
  - On the first mismatch, err is set and err_addr is loaded. Later mismatches do not change err_addr.
  - After the last compare the next state is DONE.
- DONE, 1 cycle: done = 1. Next state is IDLE.
- Outside their active states: wr_en = 0 and rd_own = 0. wr_addr, wr_data and rd_addr hold their last values; their values there are don't-care.
- cmd_valid asserted while busy is not accepted. The requester holds its command until cmd_ready is high.
- A single write never triggers verify and never changes err, except that the handshake clears it.
- Reset (reset_n low, asynchronous):
  - state = IDLE; wr_en = 0, rd_own = 0, done = 0, busy = 0, err = 0.
  - wr_addr = 0, wr_data = 0, rd_addr = 0, err_addr = 0.
  - The verify pipeline is cleared. cmd_ready = 1 once reset_n is high.
  - Reset in the middle of a fill leaves a partially written RAM. No recovery is attempted.

## Timing
- Let handshake edge = cycle 0.
- Single write: wr_en high in cycle 1; done high in cycle 2; cmd_ready high again in cycle 3.
- Fill: wr_en high in cycles 1..32; verify reads issue in cycles 33..64.
  - The last compare falls in cycle 64 + RD_LAT.
  - done is high in cycle 65 + RD_LAT, which is cycle 67 at default.
  - cmd_ready is high again the following cycle.
- All outputs are registered. No combinational path exists from cmd_* to wr_*. cmd_ready is decoded from registered state.
- Read/write collision cannot occur during verify, because all writes finish before the first read.

## Test plan
- Reset then single write: cmd_op=0, addr=5'h13, data=4'hA, one handshake.
  - wr_en pulses in cycle 1 with wr_addr=0x13 and wr_data=A; done pulses in cycle 2.
  - Reading address 0x13 through the scanner then returns A.
- Incrementing fill: cmd_op=1, cmd_inc=1, data=4'h3.
  - wr_data sequence is 3,4,…,F,0,1,…; address 31 is written with 2.
  - done is in cycle 67 with err=0.
- Constant fill with a corrupted RAM model: cmd_inc=0, data=4'h7, and the bench forces rd_q=4'h0 when reading address 9 and address 20.
  - err=1, err_addr=9.
  - A following single write clears err at its handshake.
- Back-pressure: hold cmd_valid=1 continuously through a fill.
  - cmd_ready stays 0 until the cycle after done.
  - Exactly one further command is accepted. No command is lost or duplicated.
- Asynchronous reset in cycle 20 of a fill (reset_n low mid-cycle).
  - wr_en drops immediately and busy=0.
  - No done pulse; cmd_ready=1 after release.
  - A new fill then completes with err=0.
- Parameter sweep RD_LAT=1 and RD_LAT=4 with an incrementing fill: done lands in cycles 66 and 69 respectively, with err=0.
